// File: rtl/gf2_poly_div_seq.sv
// Carry-less GF(2) long divider A/B -> Q,R, one dividend bit per cycle; (M-d)+N cycles from accept (M if B==0).
// Result is held in DONE until out_ready; operands are accepted only in IDLE, never in the handoff cycle.
module gf2_poly_div_seq #(
  parameter int M = 10,
  parameter int N = 19
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [N-1:0] dividend,
  input  logic [M-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic [M-2:0] remainder,
  output logic         div_by_zero
);

  localparam int DW = (M > 1) ? $clog2(M) : 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, DEG, DIV, DONE} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  w, w_nxt;
  logic [N-1:0]  q, q_nxt;
  logic [M-1:0]  dv, dv_nxt;
  logic [DW-1:0] idx, idx_nxt;
  logic [DW-1:0] d, d_nxt;
  logic [IW-1:0] i, i_nxt;
  logic [IW-1:0] sh;
  logic [N-1:0]  dsh;
  logic [N-1:0]  quo_nxt;
  logic [M-2:0]  rem_nxt;
  logic          dbz_nxt;
  logic          accept;
  logic          hit;

  assign start_ready = (state == IDLE) && rst_n;
  assign accept      = start_valid && start_ready;
  assign out_valid   = (state == DONE);

  // Divisor aligned so its leading term sits under working bit i.
  assign sh  = i - IW'(d);
  assign dsh = N'(dv) << sh;
  assign hit = (i >= IW'(d)) && w[i];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      w           <= '0;
      q           <= '0;
      dv          <= '0;
      idx         <= '0;
      d           <= '0;
      i           <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_nxt;
      w           <= w_nxt;
      q           <= q_nxt;
      dv          <= dv_nxt;
      idx         <= idx_nxt;
      d           <= d_nxt;
      i           <= i_nxt;
      quotient    <= quo_nxt;
      remainder   <= rem_nxt;
      div_by_zero <= dbz_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    w_nxt     = w;
    q_nxt     = q;
    dv_nxt    = dv;
    idx_nxt   = idx;
    d_nxt     = d;
    i_nxt     = i;
    quo_nxt   = quotient;
    rem_nxt   = remainder;
    dbz_nxt   = div_by_zero;
    unique case (state)
      IDLE: begin
        if (accept) begin
          w_nxt     = dividend;
          dv_nxt    = divisor;
          idx_nxt   = DW'(M - 1);
          q_nxt     = '0;
          dbz_nxt   = 1'b0;
          state_nxt = DEG;
        end
      end
      DEG: begin
        if (dv[idx]) begin
          d_nxt     = idx;
          i_nxt     = IW'(N - 1);
          state_nxt = DIV;
        end else if (idx == '0) begin
          dbz_nxt   = 1'b1;
          quo_nxt   = '0;
          rem_nxt   = '0;
          state_nxt = DONE;
        end else begin
          idx_nxt = idx - DW'(1);
        end
      end
      DIV: begin
        if (hit) begin
          w_nxt = w ^ dsh;
          q_nxt = q | (N'(1) << sh);
        end
        if (i == '0) begin
          quo_nxt   = q_nxt;
          rem_nxt   = w_nxt[M-2:0];
          state_nxt = DONE;
        end else begin
          i_nxt = i - IW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Every term at or above the divisor degree must be cancelled by the last DIV step.
  assert property (@(posedge clk) disable iff (!rst_n)
    (state == DIV && i == '0) |-> (w_nxt[N-1:M-1] == '0));

  assert property (@(posedge clk) disable iff (!rst_n)
    (state == DONE && !out_ready) |=> $stable({quotient, remainder, div_by_zero}));

endmodule

// File: tb/tb_gf2_poly_div_seq.sv
// Scoreboarded bench for gf2_poly_div_seq: directed cases, hold/backpressure, mid-run reset, random sweep.
module tb_gf2_poly_div_seq;
  localparam int M = 10;
  localparam int N = 19;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_valid;
  logic         start_ready;
  logic [N-1:0] dividend;
  logic [M-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] quotient;
  logic [M-2:0] remainder;
  logic         div_by_zero;

  always #5 clk = ~clk;

  gf2_poly_div_seq #(.M(M), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  typedef struct {
    logic [N-1:0] a;
    logic [M-1:0] b;
    logic [N-1:0] q;
    logic [M-2:0] r;
    logic         dbz;
    int           lat;
    bit           know_qr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   hold_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] clmul(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] p;
    p = '0;
    for (int j = 0; j < 32; j++) if (b[j]) p ^= a << j;
    return p;
  endfunction

  function automatic int deg(input logic [31:0] v);
    int dg;
    dg = -1;
    for (int j = 0; j < 32; j++) if (v[j]) dg = j;
    return dg;
  endfunction

  function automatic int exp_lat(input logic [M-1:0] b);
    if (b == '0) return M;
    return (M - deg(32'(b))) + N;
  endfunction

  // Called at posedge+1; returns at posedge+1 right after the accept edge.
  task automatic issue(input logic [N-1:0] a, input logic [M-1:0] b, input bit know,
                       input logic [N-1:0] eq, input logic [M-2:0] er);
    exp_t e;
    int   n;
    n = 0;
    while (!start_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!start_ready) begin
      chk("start_ready_timeout", 64'(start_ready), 64'd1);
      return;
    end
    e.a       = a;
    e.b       = b;
    e.dbz     = (b == '0);
    e.lat     = exp_lat(b);
    e.know_qr = know || (b == '0);
    e.q       = (b == '0) ? '0 : eq;
    e.r       = (b == '0) ? '0 : er;
    exp_q.push_back(e);
    dividend    = a;
    divisor     = b;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    dividend    = N'($urandom);
    divisor     = M'($urandom);
    chk("dbz_cleared_on_accept", 64'(div_by_zero), 64'd0);
    chk("start_ready_busy", 64'(start_ready), 64'd0);
  endtask

  initial begin : ready_gen
    forever begin
      @(posedge clk); #1;
      if (!hold_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : monitor
    exp_t         e;
    bit           busy;
    logic [N-1:0] hq;
    logic [M-2:0] hr;
    logic         hd;
    busy = 1'b0;
    hq = '0;
    hr = '0;
    hd = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 1'b0;
        hq   = '0;
        hr   = '0;
        hd   = 1'b0;
      end else begin
        if (out_valid && !busy) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_result", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("latency", 64'(cyc - acc_cyc), 64'(e.lat));
            chk("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
            if (e.know_qr) begin
              chk("quotient", 64'(quotient), 64'(e.q));
              chk("remainder", 64'(remainder), 64'(e.r));
            end
            if (!e.dbz) begin
              chk("identity_a_eq_qb_xor_r",
                  64'(clmul(32'(quotient), 32'(e.b)) ^ 32'(remainder)), 64'(e.a));
              chk("rem_deg_below_div_deg", 64'(deg(32'(remainder)) < deg(32'(e.b))), 64'd1);
            end
          end
          busy = 1'b1;
          hq   = quotient;
          hr   = remainder;
          hd   = div_by_zero;
        end else if (out_valid) begin
          chk("hold_quotient", 64'(quotient), 64'(hq));
          chk("hold_remainder", 64'(remainder), 64'(hr));
          chk("hold_div_by_zero", 64'(div_by_zero), 64'(hd));
        end else begin
          chk("idle_quotient", 64'(quotient), 64'(hq));
          chk("idle_remainder", 64'(remainder), 64'(hr));
        end
        if (out_valid) chk("start_ready_in_done", 64'(start_ready), 64'd0);
        if (start_valid && start_ready) acc_cyc = cyc + 1;
        if (out_valid && out_ready) busy = 1'b0;
      end
    end
  end

  initial begin : driver
    int          n;
    logic [31:0] ra, rb, rp;
    rst_n       = 1'b0;
    start_valid = 1'b0;
    dividend    = '0;
    divisor     = '0;
    out_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_start_ready", 64'(start_ready), 64'd0);
    chk("reset_quotient", 64'(quotient), 64'd0);
    chk("reset_remainder", 64'(remainder), 64'd0);
    chk("reset_div_by_zero", 64'(div_by_zero), 64'd0);
    rst_n = 1'b1;

    issue(19'h00005, 10'h003, 1'b1, 19'h00003, 9'h000);
    issue(19'h7FFFF, 10'h001, 1'b1, 19'h7FFFF, 9'h000);
    issue(19'h00200, 10'h211, 1'b1, 19'h00001, 9'h011);
    issue(19'h12345, 10'h000, 1'b1, 19'h00000, 9'h000);
    issue(19'h00005, 10'h003, 1'b1, 19'h00003, 9'h000);

    // Result held under backpressure while start_valid toggles.
    issue(19'h0ABCD, 10'h2C5, 1'b0, '0, '0);
    hold_rdy  = 1'b1;
    out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("hold_reached_done", 64'(out_valid), 64'd1);
    for (int k = 0; k < 5; k++) begin
      start_valid = (k % 2 == 0);
      dividend    = N'($urandom);
      divisor     = M'($urandom) | M'(1);
      @(posedge clk); #1;
      chk("hold_no_accept_ready", 64'(start_ready), 64'd0);
      chk("hold_still_valid", 64'(out_valid), 64'd1);
    end
    start_valid = 1'b0;
    out_ready   = 1'b1;
    @(posedge clk); #1;
    chk("handoff_valid_low", 64'(out_valid), 64'd0);
    chk("handoff_start_ready", 64'(start_ready), 64'd1);
    hold_rdy = 1'b0;

    // Reset while dividing.
    issue(19'h00005, 10'h003, 1'b1, 19'h00003, 9'h000);
    repeat (12) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_start_ready", 64'(start_ready), 64'd0);
    chk("midrst_quotient", 64'(quotient), 64'd0);
    chk("midrst_remainder", 64'(remainder), 64'd0);
    chk("midrst_div_by_zero", 64'(div_by_zero), 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("after_rst_start_ready", 64'(start_ready), 64'd1);

    for (int k = 0; k < 40; k++) begin
      ra = $urandom_range(0, (1 << (N - M + 1)) - 1);
      rb = $urandom_range(1, (1 << M) - 1);
      rp = clmul(ra, rb);
      issue(rp[N-1:0], rb[M-1:0], 1'b1, ra[N-1:0], '0);
    end
    for (int k = 0; k < 20; k++) begin
      rb = $urandom_range(1, (1 << M) - 1);
      issue(N'($urandom), rb[M-1:0], 1'b0, '0, '0);
    end
    issue(N'($urandom), 10'h000, 1'b1, '0, '0);
    issue(19'h7FFFF, 10'h3FF, 1'b0, '0, '0);

    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_pending_results", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
